// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and default parameters for data_memory_ctrl
package mem_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_DEPTH    = 16;
    localparam int DEF_READ_LAT = 1;

endpackage

// File: rtl/data_memory_ctrl_if.sv
// rtl/data_memory_ctrl_if.sv - request/response bus between a requester and data_memory_ctrl
interface data_memory_ctrl_if
    import mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic                  clear;
    logic                  req_valid;
    logic                  req_ready;
    logic                  mem_write;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W-1:0]     in_data;
    logic [DATA_W/8-1:0]   byte_en;
    logic                  resp_valid;
    logic [DATA_W-1:0]     out_data;
    logic                  resp_err;
    logic                  busy;

    modport master (
        output clear, req_valid, mem_write, address, in_data, byte_en,
        input  req_ready, resp_valid, out_data, resp_err, busy
    );

    modport slave (
        input  clear, req_valid, mem_write, address, in_data, byte_en,
        output req_ready, resp_valid, out_data, resp_err, busy
    );

endinterface

// File: rtl/mem_resp_pipe.sv
// rtl/mem_resp_pipe.sv - fixed-latency {valid, err, data} response shift register
module mem_resp_pipe #(
    parameter int DATA_W = 16,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_err,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic              out_err,
    output logic [DATA_W-1:0] out_data
);

    logic [LAT-1:0]    vld;
    logic [LAT-1:0]    err;
    logic [DATA_W-1:0] dat [LAT];

    // Err and data are forced to zero when not valid, so the outputs stay clean between responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
            err <= '0;
            for (int i = 0; i < LAT; i++) begin
                dat[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            err[0] <= in_valid && in_err;
            dat[0] <= in_valid ? in_data : '0;
            for (int i = 1; i < LAT; i++) begin
                vld[i] <= vld[i-1];
                err[i] <= err[i-1];
                dat[i] <= dat[i-1];
            end
        end
    end

    assign out_valid = vld[LAT-1];
    assign out_err   = err[LAT-1];
    assign out_data  = dat[LAT-1];

endmodule

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - zero-filled word memory with byte-enabled writes and fixed-latency responses
module data_memory_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int READ_LAT = DEF_READ_LAT
) (
    input  logic              clk,
    input  logic              reset,
    data_memory_ctrl_if.slave bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NB    = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t            state;
    logic [IDX_W-1:0]  fill_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_data;

    assign accept   = bus.req_valid && bus.req_ready;
    assign in_range = {1'b0, bus.address} < DEPTH_L;
    assign idx      = bus.address[IDX_W-1:0];

    assign bus.req_ready = (state == RUN);
    assign bus.busy      = (state == FILL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FILL;
            fill_cnt <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (fill_cnt == LAST_IDX) begin
                        state    <= RUN;
                        fill_cnt <= '0;
                    end else begin
                        fill_cnt <= fill_cnt + IDX_W'(1);
                    end
                end
                RUN: begin
                    if (bus.clear) begin
                        state    <= FILL;
                        fill_cnt <= '0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    // Single write port: the fill owns it in FILL, requests only reach it in RUN.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == FILL) begin
                mem[fill_cnt] <= '0;
            end else if (accept && bus.mem_write && in_range) begin
                for (int b = 0; b < NB; b++) begin
                    if (bus.byte_en[b]) begin
                        mem[idx][b*8 +: 8] <= bus.in_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    assign rd_data = (accept && !bus.mem_write && in_range) ? mem[idx] : '0;

    mem_resp_pipe #(
        .DATA_W (DATA_W),
        .LAT    (READ_LAT)
    ) u_resp_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (accept),
        .in_err    (!in_range),
        .in_data   (rd_data),
        .out_valid (bus.resp_valid),
        .out_err   (bus.resp_err),
        .out_data  (bus.out_data)
    );

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - directed bench driving READ_LAT=2 and READ_LAT=3 instances in lockstep
module tb_data_memory_ctrl;

    typedef struct {
        int          cyc;
        logic        err;
        logic [15:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        req_valid = 1'b0;
    logic        mem_write = 1'b0;
    logic [4:0]  address = '0;
    logic [15:0] in_data = '0;
    logic [1:0]  byte_en = '0;

    int    cyc = 0;
    int    n_vec = 0;
    int    n_err = 0;
    int    bad_idle = 0;
    resp_t q2[$];
    resp_t q3[$];
    resp_t expq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_memory_ctrl_if #(.DATA_W(16), .ADDR_W(5)) b2 ();
    data_memory_ctrl_if #(.DATA_W(16), .ADDR_W(5)) b3 ();

    assign b2.clear = clear;     assign b3.clear = clear;
    assign b2.req_valid = req_valid; assign b3.req_valid = req_valid;
    assign b2.mem_write = mem_write; assign b3.mem_write = mem_write;
    assign b2.address = address; assign b3.address = address;
    assign b2.in_data = in_data; assign b3.in_data = in_data;
    assign b2.byte_en = byte_en; assign b3.byte_en = byte_en;

    data_memory_ctrl #(.DATA_W(16), .ADDR_W(5), .DEPTH(16), .READ_LAT(2)) u2 (
        .clk(clk), .reset(reset), .bus(b2));
    data_memory_ctrl #(.DATA_W(16), .ADDR_W(5), .DEPTH(16), .READ_LAT(3)) u3 (
        .clk(clk), .reset(reset), .bus(b3));

    always @(negedge clk) begin
        if (b2.resp_valid === 1'b1) q2.push_back('{cyc, b2.resp_err, b2.out_data});
        if (b3.resp_valid === 1'b1) q3.push_back('{cyc, b3.resp_err, b3.out_data});
        if (b2.resp_valid === 1'b0 && (b2.out_data !== 16'h0 || b2.resp_err !== 1'b0)) bad_idle++;
        if (b3.resp_valid === 1'b0 && (b3.out_data !== 16'h0 || b3.resp_err !== 1'b0)) bad_idle++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One request, driven at a negedge and accepted at the next posedge.
    task automatic access(input logic we, input logic [4:0] addr, input logic [15:0] d,
                          input logic [1:0] be, input logic err, input logic [15:0] exp);
        req_valid = 1'b1;
        mem_write = we;
        address   = addr;
        in_data   = d;
        byte_en   = be;
        expq.push_back('{cyc, err, exp});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic settle(input string tag);
        repeat (5) @(negedge clk);
        check_eq({tag, "_cnt2"}, q2.size(), expq.size());
        check_eq({tag, "_cnt3"}, q3.size(), expq.size());
        foreach (expq[i]) begin
            if (i < q2.size()) begin
                check_eq($sformatf("%s_cyc2[%0d]", tag, i), q2[i].cyc, expq[i].cyc + 2);
                check_eq($sformatf("%s_err2[%0d]", tag, i), q2[i].err, expq[i].err);
                check_eq($sformatf("%s_dat2[%0d]", tag, i), q2[i].data, expq[i].data);
            end
            if (i < q3.size()) begin
                check_eq($sformatf("%s_cyc3[%0d]", tag, i), q3[i].cyc, expq[i].cyc + 3);
                check_eq($sformatf("%s_err3[%0d]", tag, i), q3[i].err, expq[i].err);
                check_eq($sformatf("%s_dat3[%0d]", tag, i), q3[i].data, expq[i].data);
            end
        end
        q2.delete();
        q3.delete();
        expq.delete();
    endtask

    // Counts consecutive busy samples from the current negedge; optionally pokes clear mid-fill.
    task automatic count_fill(input string tag, input bit poke_clear);
        int n = 0;
        int rdy_bad = 0;
        while (b2.busy === 1'b1 && n < 40) begin
            n++;
            if (b2.req_ready !== 1'b0 || b3.req_ready !== 1'b0 || b3.busy !== 1'b1) rdy_bad++;
            clear = poke_clear && (n == 5);
            @(negedge clk);
        end
        clear = 1'b0;
        check_eq({tag, "_len"}, n, 16);
        check_eq({tag, "_rdy"}, rdy_bad, 0);
        check_eq({tag, "_run"}, {b2.req_ready, b3.req_ready, b3.busy}, 3'b110);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_ready", {b2.req_ready, b3.req_ready}, 2'b00);
        check_eq("rst_busy", {b2.busy, b3.busy}, 2'b11);
        check_eq("rst_valid", {b2.resp_valid, b3.resp_valid}, 2'b00);
        check_eq("rst_data", {b2.out_data, b3.out_data}, 32'h0);
        check_eq("rst_err", {b2.resp_err, b3.resp_err}, 2'b00);

        reset = 1'b0;
        count_fill("fill0", 1'b0);
        for (int a = 0; a < 16; a++) access(1'b0, 5'(a), 16'h0, 2'b00, 1'b0, 16'h0);
        settle("zero");

        access(1'b1, 5'd10, 16'h1234, 2'b11, 1'b0, 16'h0);
        access(1'b0, 5'd10, 16'h0,    2'b00, 1'b0, 16'h1234);
        settle("b2b");

        access(1'b1, 5'd3, 16'hFFFF, 2'b11, 1'b0, 16'h0);
        access(1'b1, 5'd3, 16'hAB00, 2'b10, 1'b0, 16'h0);
        access(1'b0, 5'd3, 16'h0,    2'b00, 1'b0, 16'hABFF);
        access(1'b1, 5'd5, 16'h00CD, 2'b01, 1'b0, 16'h0);
        access(1'b0, 5'd5, 16'h0,    2'b00, 1'b0, 16'h00CD);
        settle("bytes");

        access(1'b1, 5'd4,  16'h5A5A, 2'b11, 1'b0, 16'h0);
        access(1'b0, 5'd4,  16'h0,    2'b00, 1'b0, 16'h5A5A);
        access(1'b1, 5'd20, 16'hDEAD, 2'b11, 1'b1, 16'h0);
        access(1'b0, 5'd4,  16'h0,    2'b00, 1'b0, 16'h5A5A);
        access(1'b1, 5'd15, 16'h7777, 2'b11, 1'b0, 16'h0);
        access(1'b1, 5'd16, 16'h1111, 2'b11, 1'b1, 16'h0);
        access(1'b0, 5'd16, 16'h0,    2'b00, 1'b1, 16'h0);
        access(1'b0, 5'd15, 16'h0,    2'b00, 1'b0, 16'h7777);
        access(1'b0, 5'd0,  16'h0,    2'b00, 1'b0, 16'h0);
        settle("range");

        access(1'b1, 5'd13, 16'd89, 2'b11, 1'b0, 16'h0);
        clear = 1'b1;
        access(1'b0, 5'd13, 16'h0, 2'b00, 1'b0, 16'd89);
        clear = 1'b0;
        count_fill("clrfill", 1'b1);
        access(1'b0, 5'd13, 16'h0, 2'b00, 1'b0, 16'h0);
        access(1'b0, 5'd10, 16'h0, 2'b00, 1'b0, 16'h0);
        access(1'b0, 5'd15, 16'h0, 2'b00, 1'b0, 16'h0);
        settle("clear");

        req_valid = 1'b1;
        mem_write = 1'b0;
        address   = 5'd1;
        @(negedge clk);
        address   = 5'd2;
        @(negedge clk);
        address   = 5'd3;
        reset     = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("midrst_valid", {b2.resp_valid, b3.resp_valid}, 2'b00);
        check_eq("midrst_busy", {b2.busy, b3.busy}, 2'b11);
        @(negedge clk);
        reset = 1'b0;
        count_fill("refill", 1'b0);
        repeat (4) @(negedge clk);
        check_eq("midrst_q3", q3.size(), 0);
        check_eq("midrst_q2", q2.size(), 1);
        q2.delete();
        q3.delete();
        access(1'b0, 5'd10, 16'h0, 2'b00, 1'b0, 16'h0);
        settle("post");

        check_eq("idle_zero", bad_idle, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
